// File: rtl/dlt_sweep_checker.sv
`timescale 1ns/1ps
// Sweeps a fixed 8-step (sr,g,d) pattern over CHANNELS latches and checks q against
// a per-channel expected model. Define DLT_SWEEP_ERRCNT_EN to enable the err_cnt counter.
module dlt_sweep_checker #(
  parameter int                  CHANNELS     = 32,
  parameter int                  SETTLE       = 2,
  parameter logic [CHANNELS-1:0] G_INV_MASK   = '0,
  parameter logic [CHANNELS-1:0] SR_INV_MASK  = '0,
  parameter logic [CHANNELS-1:0] SR_VAL_MASK  = '0,
  parameter logic [CHANNELS-1:0] INIT_MASK    = '0,
  parameter logic [CHANNELS-1:0] D_SEL_MASK   = '1,
  parameter logic [CHANNELS-1:0] D_CONST_MASK = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CHANNELS-1:0] q,
  output logic                d,
  output logic                g,
  output logic                sr,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [5:0]          fail_ch,
  output logic [2:0]          fail_step,
  output logic [7:0]          err_cnt
);

  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_SETTLE, ST_CHECK, ST_FINISH} state_t;

  state_t              state;
  logic [2:0]          step;
  logic [3:0]          wait_cnt;
  logic [CHANNELS-1:0] model;
  logic [CHANNELS-1:0] model_next;
  logic [CHANNELS-1:0] se;
  logic [CHANNELS-1:0] ge;
  logic [CHANNELS-1:0] di;
  logic [CHANNELS-1:0] mismatch;
  logic [5:0]          first_ch;

  // Step table, packed as {sr, g, d}.
  function automatic logic [2:0] step_stim(input logic [2:0] s);
    case (s)
      3'd0:    step_stim = 3'b100;
      3'd1:    step_stim = 3'b011;
      3'd2:    step_stim = 3'b010;
      3'd3:    step_stim = 3'b001;
      3'd4:    step_stim = 3'b111;
      3'd5:    step_stim = 3'b000;
      3'd6:    step_stim = 3'b011;
      default: step_stim = 3'b000;
    endcase
  endfunction

  // Effective per-channel set/enable/data; set wins over enable, otherwise hold.
  assign se         = {CHANNELS{sr}} ^ SR_INV_MASK;
  assign ge         = {CHANNELS{g}} ^ G_INV_MASK;
  assign di         = (D_SEL_MASK & {CHANNELS{d}}) | (~D_SEL_MASK & D_CONST_MASK);
  assign model_next = (se & SR_VAL_MASK) | (~se & ge & di) | (~se & ~ge & model);
  assign mismatch   = q ^ model;

  // NOTE: default assignment first so no path leaves first_ch unassigned (no latch).
  always_comb begin
    first_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (mismatch[i]) first_ch = 6'(i);
  end

  // NOTE: sequential state uses non-blocking assignments only; the model register is
  // reset to INIT_MASK like any other flop, it is not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      step      <= '0;
      wait_cnt  <= '0;
      {sr, g, d} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_ch   <= '0;
      fail_step <= '0;
      model     <= INIT_MASK;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_DRIVE;
            step       <= '0;
            {sr, g, d} <= step_stim(3'd0);
            busy       <= 1'b1;
            pass       <= 1'b1;
            fail_ch    <= '0;
            fail_step  <= '0;
            model      <= INIT_MASK;
          end
        end
        ST_DRIVE: begin
          model    <= model_next;
          wait_cnt <= '0;
          state    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (wait_cnt == 4'(SETTLE - 1)) state <= ST_CHECK;
          wait_cnt <= wait_cnt + 4'd1;
        end
        ST_CHECK: begin
          // pass still high means no earlier step has failed in this sweep.
          if (pass && (|mismatch)) begin
            pass      <= 1'b0;
            fail_step <= step;
            fail_ch   <= first_ch;
          end
          if (step == 3'd7) begin
            state      <= ST_FINISH;
            {sr, g, d} <= 3'b000;
            done       <= 1'b1;
          end else begin
            step       <= step + 3'd1;
            {sr, g, d} <= step_stim(step + 3'd1);
            state      <= ST_DRIVE;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DLT_SWEEP_ERRCNT_EN
  function automatic logic [6:0] ones(input logic [CHANNELS-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < CHANNELS; i++) n = n + 7'(v[i]);
    return n;
  endfunction

  logic [8:0] err_sum;
  assign err_sum = {1'b0, err_cnt} + {2'b00, ones(mismatch)};

  always_ff @(posedge clk) begin
    if (rst)                             err_cnt <= '0;
    else if (state == ST_IDLE && start)  err_cnt <= '0;
    else if (state == ST_CHECK)          err_cnt <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule
